// File: rtl/bit_op_pkg.sv
// rtl/bit_op_pkg.sv - opcodes, FSM states and opcode helpers for bit_op_unit
package bit_op_pkg;

    localparam logic [2:0] OP_NOP    = 3'd0;
    localparam logic [2:0] OP_LD     = 3'd1;
    localparam logic [2:0] OP_AND    = 3'd2;
    localparam logic [2:0] OP_OR     = 3'd3;
    localparam logic [2:0] OP_XOR    = 3'd4;
    localparam logic [2:0] OP_NOT    = 3'd5;
    localparam logic [2:0] OP_ST     = 3'd6;
    localparam logic [2:0] OP_ANDACC = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_EXEC  = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    // Only NOP and LD leave the RAM untouched.
    function automatic logic op_writes(input logic [2:0] op);
        return !(op == OP_NOP || op == OP_LD);
    endfunction

endpackage

// File: rtl/bit_alu.sv
// rtl/bit_alu.sv - combinational bit-logic result and accumulator update
module bit_alu
    import bit_op_pkg::*;
(
    input  logic [2:0] i_op,
    input  logic       i_a,
    input  logic       i_b,
    input  logic       i_acc,
    output logic       o_r,
    output logic       o_acc_next
);

    always_comb begin
        o_r        = 1'b0;
        o_acc_next = i_acc;
        case (i_op)
            OP_NOP: begin
                o_r = i_acc;
            end
            OP_LD: begin
                o_r        = i_a;
                o_acc_next = i_a;
            end
            OP_AND: begin
                o_r        = i_a & i_b;
                o_acc_next = i_a & i_b;
            end
            OP_OR: begin
                o_r        = i_a | i_b;
                o_acc_next = i_a | i_b;
            end
            OP_XOR: begin
                o_r        = i_a ^ i_b;
                o_acc_next = i_a ^ i_b;
            end
            OP_NOT: begin
                o_r        = ~i_a;
                o_acc_next = ~i_a;
            end
            OP_ST: begin
                o_r = i_acc;
            end
            OP_ANDACC: begin
                o_r        = i_acc & i_a;
                o_acc_next = i_acc & i_a;
            end
        endcase
    end

endmodule

// File: rtl/ram_bit.sv
// rtl/ram_bit.sv - three-port bit RAM: synchronous reads on A and B, write on C
module ram_bit #(
    parameter int AWIDTH = 8
) (
    input  logic              clk,
    input  logic [AWIDTH-1:0] port_a_address,
    output logic              port_a_out,
    input  logic [AWIDTH-1:0] port_b_address,
    output logic              port_b_out,
    input  logic [AWIDTH-1:0] port_c_address,
    input  logic              port_c_data,
    input  logic              port_c_we
);

    logic r_mem [2**AWIDTH];

    // Read-before-write on a shared address: A/B return the old cell value.
    always_ff @(posedge clk) begin
        port_a_out <= r_mem[port_a_address];
        port_b_out <= r_mem[port_b_address];
        if (port_c_we) begin
            r_mem[port_c_address] <= port_c_data;
        end
    end

endmodule

// File: rtl/bit_op_unit.sv
// rtl/bit_op_unit.sv - command-driven bit-logic master owning all ram_bit address and write lines
module bit_op_unit
    import bit_op_pkg::*;
#(
    parameter int AWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [AWIDTH-1:0] cmd_addr_a,
    input  logic [AWIDTH-1:0] cmd_addr_b,
    input  logic [AWIDTH-1:0] cmd_addr_c,
    output logic              done,
    output logic              acc_out,
    output logic [AWIDTH-1:0] port_a_address,
    input  logic              port_a_out,
    output logic [AWIDTH-1:0] port_b_address,
    input  logic              port_b_out,
    output logic [AWIDTH-1:0] port_c_address,
    output logic              port_c_data,
    output logic              port_c_we
);

    state_t            r_state;
    logic [2:0]        r_op;
    logic [AWIDTH-1:0] r_addr_c;
    logic [AWIDTH-1:0] r_a_addr;
    logic [AWIDTH-1:0] r_b_addr;
    logic [AWIDTH-1:0] r_c_addr;
    logic              r_c_data;
    logic              r_acc;
    logic              r_done;
    logic              r_ready;

    logic              w_r;
    logic              w_acc_next;

    bit_alu u_alu (
        .i_op       (r_op),
        .i_a        (port_a_out),
        .i_b        (port_b_out),
        .i_acc      (r_acc),
        .o_r        (w_r),
        .o_acc_next (w_acc_next)
    );

    // done is raised on entry to the retiring state so it lines up with that state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_op     <= OP_NOP;
            r_addr_c <= '0;
            r_a_addr <= '0;
            r_b_addr <= '0;
            r_c_addr <= '0;
            r_c_data <= 1'b0;
            r_acc    <= 1'b0;
            r_done   <= 1'b0;
            r_ready  <= 1'b1;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid && r_ready) begin
                        r_op     <= cmd_op;
                        r_a_addr <= cmd_addr_a;
                        r_b_addr <= cmd_addr_b;
                        r_addr_c <= cmd_addr_c;
                        r_ready  <= 1'b0;
                        if (cmd_op == OP_NOP) begin
                            r_state <= S_EXEC;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_READ;
                        end
                    end
                end
                S_READ: begin
                    r_state <= S_EXEC;
                    r_done  <= !op_writes(r_op);
                end
                S_EXEC: begin
                    r_acc <= w_acc_next;
                    if (op_writes(r_op)) begin
                        r_c_addr <= r_addr_c;
                        r_c_data <= w_r;
                        r_done   <= 1'b1;
                        r_state  <= S_WRITE;
                    end else begin
                        r_state <= S_IDLE;
                        r_ready <= 1'b1;
                    end
                end
                S_WRITE: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    // Gating by rst suppresses both the write and the retire of an interrupted command.
    assign port_c_we      = (r_state == S_WRITE) & ~rst;
    assign done           = r_done & ~rst;
    assign cmd_ready      = r_ready;
    assign acc_out        = r_acc;
    assign port_a_address = r_a_addr;
    assign port_b_address = r_b_addr;
    assign port_c_address = r_c_addr;
    assign port_c_data    = r_c_data;

endmodule

// File: tb/tb_bit_op_unit.sv
// tb/tb_bit_op_unit.sv - scoreboard bench for bit_op_unit driving a real ram_bit
module tb_bit_op_unit;
    import bit_op_pkg::*;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_op;
    logic [AW-1:0] cmd_addr_a;
    logic [AW-1:0] cmd_addr_b;
    logic [AW-1:0] cmd_addr_c;
    logic          done;
    logic          acc_out;
    logic [AW-1:0] port_a_address;
    logic          port_a_out;
    logic [AW-1:0] port_b_address;
    logic          port_b_out;
    logic [AW-1:0] port_c_address;
    logic          port_c_data;
    logic          port_c_we;

    logic          pre_we;
    logic [AW-1:0] pre_addr;
    logic          pre_data;
    logic [AW-1:0] ram_c_addr;
    logic          ram_c_data;
    logic          ram_c_we;

    always #5 clk = ~clk;

    bit_op_unit #(.AWIDTH(AW)) u_dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_op         (cmd_op),
        .cmd_addr_a     (cmd_addr_a),
        .cmd_addr_b     (cmd_addr_b),
        .cmd_addr_c     (cmd_addr_c),
        .done           (done),
        .acc_out        (acc_out),
        .port_a_address (port_a_address),
        .port_a_out     (port_a_out),
        .port_b_address (port_b_address),
        .port_b_out     (port_b_out),
        .port_c_address (port_c_address),
        .port_c_data    (port_c_data),
        .port_c_we      (port_c_we)
    );

    // Preload path shares port C with the DUT while the DUT is idle.
    assign ram_c_we   = port_c_we | pre_we;
    assign ram_c_addr = pre_we ? pre_addr : port_c_address;
    assign ram_c_data = pre_we ? pre_data : port_c_data;

    ram_bit #(.AWIDTH(AW)) u_ram (
        .clk            (clk),
        .port_a_address (port_a_address),
        .port_a_out     (port_a_out),
        .port_b_address (port_b_address),
        .port_b_out     (port_b_out),
        .port_c_address (ram_c_addr),
        .port_c_data    (ram_c_data),
        .port_c_we      (ram_c_we)
    );

    typedef struct {
        int            id;
        int            lat;
        logic          we;
        logic          acc;
        logic [AW-1:0] c_addr;
        logic          c_data;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   next_id = 0;
    int   we_cnt = 0;
    logic chk_pend = 1'b0;
    exp_t cur;
    exp_t sb[$];
    int   acc_q[$];
    bit   model_mem [256];
    logic model_acc = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            acc_q.delete();
            chk_pend = 1'b0;
            we_cnt   = 0;
        end else begin
            if (chk_pend) begin
                chk($sformatf("acc_after_cmd%0d", cur.id), 32'(acc_out), 32'(cur.acc));
                chk($sformatf("ready_after_cmd%0d", cur.id), 32'(cmd_ready), 32'd1);
                chk_pend = 1'b0;
            end
            if (port_c_we) we_cnt++;
            if (done) begin
                if (sb.size() == 0 || acc_q.size() == 0) begin
                    chk("unexpected_done", 32'(done), 32'd0);
                end else begin
                    int a_t;
                    cur = sb.pop_front();
                    a_t = acc_q.pop_front();
                    chk($sformatf("latency_cmd%0d", cur.id), 32'(cyc - a_t + 1), 32'(cur.lat));
                    chk($sformatf("we_at_done_cmd%0d", cur.id), 32'(port_c_we), 32'(cur.we));
                    chk($sformatf("we_count_cmd%0d", cur.id), 32'(we_cnt), 32'(cur.we));
                    if (cur.we) begin
                        chk($sformatf("c_addr_cmd%0d", cur.id), 32'(port_c_address), 32'(cur.c_addr));
                        chk($sformatf("c_data_cmd%0d", cur.id), 32'(port_c_data), 32'(cur.c_data));
                    end
                    we_cnt   = 0;
                    chk_pend = 1'b1;
                end
            end
            if (cmd_valid && cmd_ready) acc_q.push_back(cyc + 1);
        end
    end

    task automatic push(input logic [2:0] op, input logic [AW-1:0] a, input logic [AW-1:0] b,
                        input logic [AW-1:0] c);
        exp_t e;
        logic va, vb, r, wr, nacc;
        va = model_mem[a];
        vb = model_mem[b];
        nacc = model_acc;
        wr = 1'b1;
        r = 1'b0;
        case (op)
            3'd0: begin wr = 1'b0; r = model_acc; end
            3'd1: begin wr = 1'b0; r = va; nacc = va; end
            3'd2: begin r = va & vb; nacc = r; end
            3'd3: begin r = va | vb; nacc = r; end
            3'd4: begin r = va ^ vb; nacc = r; end
            3'd5: begin r = ~va; nacc = r; end
            3'd6: begin r = model_acc; end
            default: begin r = model_acc & va; nacc = r; end
        endcase
        if (wr) model_mem[c] = r;
        model_acc = nacc;
        e.id     = next_id++;
        e.lat    = (op == 3'd0) ? 1 : (wr ? 3 : 2);
        e.we     = wr;
        e.acc    = nacc;
        e.c_addr = c;
        e.c_data = r;
        sb.push_back(e);
    endtask

    task automatic drive(input logic [2:0] op, input logic [AW-1:0] a, input logic [AW-1:0] b,
                         input logic [AW-1:0] c);
        bit ok = 0;
        cmd_op     = op;
        cmd_addr_a = a;
        cmd_addr_b = b;
        cmd_addr_c = c;
        cmd_valid  = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                @(posedge clk);
                #1;
                ok = 1;
            end
        end
        if (!ok) chk("accept_timeout", 32'(cmd_ready), 32'd1);
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 30 && !ok; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !chk_pend && cmd_ready) ok = 1;
        end
        if (!ok) chk("idle_timeout", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [2:0] op, input logic [AW-1:0] a, input logic [AW-1:0] b,
                       input logic [AW-1:0] c);
        push(op, a, b, c);
        drive(op, a, b, c);
        cmd_valid = 1'b0;
        wait_idle();
    endtask

    task automatic preload(input logic [AW-1:0] addr, input logic val);
        pre_addr = addr;
        pre_data = val;
        pre_we   = 1'b1;
        model_mem[addr] = val;
        @(posedge clk);
        #1;
        pre_we = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_op     = 3'd0;
        cmd_addr_a = '0;
        cmd_addr_b = '0;
        cmd_addr_c = '0;
        pre_we     = 1'b0;
        pre_addr   = '0;
        pre_data   = 1'b0;

        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("reset_ready", 32'(cmd_ready), 32'd1);
            chk("reset_done", 32'(done), 32'd0);
            chk("reset_acc", 32'(acc_out), 32'd0);
            chk("reset_we", 32'(port_c_we), 32'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;

        preload(8'h10, 1'b1);
        preload(8'h11, 1'b0);
        preload(8'h30, 1'b1);
        preload(8'h40, 1'b0);
        preload(8'hFF, 1'b1);

        run(OP_AND, 8'h10, 8'h11, 8'h20);
        run(OP_LD,  8'h20, 8'h00, 8'h00);
        run(OP_OR,  8'h10, 8'h11, 8'h20);
        run(OP_LD,  8'h20, 8'h00, 8'h00);

        run(OP_LD,  8'h10, 8'h00, 8'h00);
        run(OP_NOT, 8'h10, 8'h00, 8'h10);
        run(OP_ST,  8'h00, 8'h00, 8'hFF);
        run(OP_LD,  8'hFF, 8'h00, 8'h00);
        run(OP_LD,  8'h10, 8'h00, 8'h00);

        run(OP_XOR, 8'h30, 8'h30, 8'h30);
        run(OP_LD,  8'h30, 8'h00, 8'h00);

        run(OP_LD,     8'h20, 8'h00, 8'h00);
        run(OP_NOP,    8'h00, 8'h00, 8'h00);
        run(OP_ANDACC, 8'h20, 8'h00, 8'h50);
        run(OP_LD,     8'h50, 8'h00, 8'h00);

        // Second command is presented throughout the first one's busy window.
        push(OP_AND, 8'h10, 8'h11, 8'h60);
        drive(OP_AND, 8'h10, 8'h11, 8'h60);
        push(OP_OR, 8'h20, 8'h11, 8'h61);
        drive(OP_OR, 8'h20, 8'h11, 8'h61);
        cmd_valid = 1'b0;
        wait_idle();
        run(OP_LD, 8'h61, 8'h00, 8'h00);
        run(OP_LD, 8'h60, 8'h00, 8'h00);

        drive(OP_OR, 8'h20, 8'h11, 8'h40);
        cmd_valid = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_in_write_done", 32'(done), 32'd0);
        chk("rst_in_write_we", 32'(port_c_we), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_acc = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 32'(cmd_ready), 32'd1);
        chk("acc_after_rst", 32'(acc_out), 32'd0);
        @(posedge clk);
        #1;
        run(OP_LD, 8'h40, 8'h00, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bit_op_unit.md
Name: bit_op_unit

Overview:
- Command-driven master for the three-port bit RAM: read ports A and B, write port C.
- Accepts one bit-logic command per handshake and reads up to two operand bits.
- Computes the result, updates a 1-bit accumulator and writes the result back through port C.
- Sits between the PBLcpu decoder and ram_bit. It is the single owner of all RAM address and write-enable lines.

Parameters:
- AWIDTH, 8, bit-RAM address width (2**AWIDTH cells).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  unit idle and able to accept a command.
- cmd_op  in  3  opcode.
- cmd_addr_a  in  AWIDTH  source A address.
- cmd_addr_b  in  AWIDTH  source B address.
- cmd_addr_c  in  AWIDTH  destination address.
- done  out  1  one-cycle pulse when a command retires.
- acc_out  out  1  accumulator value.
- port_a_address  out  AWIDTH  to ram_bit port A.
- port_a_out  in  1  from ram_bit port A.
- port_b_address  out  AWIDTH  to ram_bit port B.
- port_b_out  in  1  from ram_bit port B.
- port_c_address  out  AWIDTH  to ram_bit port C.
- port_c_data  out  1  write data.
- port_c_we  out  1  write enable.

Behaviour:
- Reset values: state=IDLE, cmd_ready=1, done=0, acc_out=0, all addresses=0, port_c_data=0, port_c_we=0.
- Opcodes (opcode: result R, write, acc):
  - 0 NOP: no RAM access, no write, acc unchanged.
  - 1 LD: R=A, no write, acc=R.
  - 2 AND: R=A&B, write, acc=R.
  - 3 OR: R=A|B, write, acc=R.
  - 4 XOR: R=A^B, write, acc=R.
  - 5 NOT: R=~A, write, acc=R.
  - 6 ST: R=acc, write, acc unchanged.
  - 7 ANDACC: R=acc&A, write, acc=R.
- Handshake: a command is accepted on an edge where cmd_valid & cmd_ready.
  - Fields are captured into registers on that edge.
  - cmd_ready drops on the next cycle and stays low until the unit returns to IDLE.
- FSM: IDLE -> READ -> EXEC -> (WRITE | IDLE) -> IDLE.
  - IDLE: cmd_ready=1. On accept: latch fields and drive port_a/b_address from them, go to READ. NOP goes directly to EXEC.
  - READ: addresses held stable for one cycle. This allows a synchronous-read RAM; a combinational RAM is also tolerated.
  - EXEC: sample port_a_out/port_b_out, compute R, update acc.
    - Writing op: register port_c_address=addr_c and port_c_data=R, go to WRITE.
    - Non-writing op: pulse done, go to IDLE.
  - WRITE: port_c_we=(state==WRITE) & ~rst; the RAM stores on the edge ending this cycle. Pulse done, go to IDLE.
- Latency, counting the accept edge as cycle 0:
  - Writing op: done in cycle 3, cmd_ready high in cycle 4. Throughput is 1 writing op per 4 cycles.
  - LD: done in cycle 2.
  - NOP: done in cycle 1.
- Addresses held: port A/B addresses hold their last values outside IDLE accept. Port C address and data hold after WRITE. Only port_c_we matters to the RAM.
- Read-after-write: the next command's READ starts after WRITE completes, so it always reads the newly written value. No forwarding is needed.
- Same-address operands: addr_a==addr_b, addr_c==addr_a, and similar aliasing are all legal. Reads complete before the write.
- Address width: addresses wrap naturally at AWIDTH bits, and cell 2**AWIDTH-1 is fully usable. There is no range checking.
- cmd_valid while busy: ignored; the command is held by the producer. Deasserting cmd_valid before acceptance is legal.
- Reset mid-operation:
  - All registers return to reset values on the next edge.
  - port_c_we is gated by rst, so a reset asserted during WRITE suppresses that write.
  - The captured command is discarded and no done pulse is produced.
- Unknown opcodes: none; all 3-bit values are defined.

Decomposition:
- Package bit_op_pkg:
  - Opcode localparams OP_NOP..OP_ANDACC.
  - FSM state encoding S_IDLE, S_READ, S_EXEC, S_WRITE.
  - Helper function op_writes(op).
- Optional sub-module bit_alu: combinational (op, a, b, acc) -> (r, acc_next).
- FSM and registers stay in bit_op_unit.
- The bench instantiates bit_op_unit with a real ram_bit (AWIDTH=8).

Test Plan:
- Reset: hold rst 2 cycles -> cmd_ready=1, done=0, acc_out=0, port_c_we=0 throughout.
- Preload cells 0x10=1 and 0x11=0, then AND a=0x10 b=0x11 c=0x20 -> port_c_we high exactly 1 cycle (cycle 3), cell 0x20=0, acc=0, done at cycle 3.
  - Repeat with OR -> cell 0x20=1.
- Chain: LD a=0x10 (done cycle 2, acc=1), then NOT a=0x10 c=0x10 (cell 0x10=0), then ST c=0xFF -> cell 0xFF=0 (wrap-boundary address).
- Aliasing: XOR a=0x30 b=0x30 c=0x30 with cell 0x30=1 -> cell 0x30=0. Next command reads 0x30 -> 0.
- Busy ignore: hold cmd_valid high with a new command during READ/EXEC/WRITE -> not accepted until cmd_ready returns, then executed exactly once.
- Reset during WRITE of OR to 0x40 (old value 0, result 1) -> cell 0x40 stays 0, no done pulse, cmd_ready=1 the cycle after reset deasserts.
